// File: rtl/xbus_arbiter.sv
// xbus_arbiter: round-robin sharing of one xbus slave port among CPU, disk DMA and spy.
// Latches the winner's request, times out silent slaves and drains late acks.
module xbus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  m_req,
  input  logic [2:0]  m_write,
  input  logic [65:0] m_addr,
  input  logic [95:0] m_wdata,
  output logic [2:0]  m_ack,
  output logic [2:0]  m_err,
  output logic [31:0] m_rdata,
  output logic [2:0]  grant,
  output logic        xbus_req,
  output logic        xbus_write,
  output logic [21:0] xbus_addr,
  output logic [31:0] xbus_wdata,
  input  logic [31:0] xbus_rdata,
  input  logic        xbus_ack
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_REL
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nx;
  logic [1:0]  last_grant;
  logic [1:0]  owner;
  logic [1:0]  win;
  logic [1:0]  o0;
  logic [1:0]  o1;
  logic [1:0]  o2;
  logic [7:0]  timer;
  logic        timeout_hit;
  logic [21:0] addr_a  [3];
  logic [31:0] wdata_a [3];

  for (genvar i = 0; i < 3; i++) begin : g_split
    assign addr_a[i]  = m_addr[22*i +: 22];
    assign wdata_a[i] = m_wdata[32*i +: 32];
  end

  // scan order starts just after the previous owner
  always_comb begin
    case (last_grant)
      2'd0: begin
        o0 = 2'd1; o1 = 2'd2; o2 = 2'd0;
      end
      2'd1: begin
        o0 = 2'd2; o1 = 2'd0; o2 = 2'd1;
      end
      default: begin
        o0 = 2'd0; o1 = 2'd1; o2 = 2'd2;
      end
    endcase
    if (m_req[o0])      win = o0;
    else if (m_req[o1]) win = o1;
    else                win = o2;
  end

  assign timeout_hit = (timer == TMO_LAST);
  assign xbus_req    = (state == S_REQ);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (|m_req) state_nx = S_REQ;
      S_REQ:   if (xbus_ack || timeout_hit) state_nx = S_REL;
      S_REL:   if (!xbus_ack) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ack      <= '0;
      m_err      <= '0;
      m_rdata    <= '0;
      grant      <= '0;
      owner      <= '0;
      last_grant <= 2'd2;
      timer      <= '0;
      xbus_write <= 1'b0;
      xbus_addr  <= '0;
      xbus_wdata <= '0;
    end else begin
      m_ack <= '0;
      m_err <= '0;
      case (state)
        S_IDLE: begin
          if (|m_req) begin
            owner      <= win;
            grant      <= 3'b001 << win;
            xbus_write <= m_write[win];
            xbus_addr  <= addr_a[win];
            xbus_wdata <= wdata_a[win];
            timer      <= '0;
          end
        end
        S_REQ: begin
          timer <= timer + 8'd1;
          if (xbus_ack) begin
            if (!xbus_write) m_rdata <= xbus_rdata;
            m_ack      <= grant;
            last_grant <= owner;
          end else if (timeout_hit) begin
            m_ack      <= grant;
            m_err      <= grant;
            m_rdata    <= '0;
            last_grant <= owner;
          end
        end
        S_REL: begin
          if (!xbus_ack) grant <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xbus_arbiter.sv
// tb_xbus_arbiter: directed checks of xbus_arbiter with TIMEOUT=8.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_xbus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  m_req = '0;
  logic [2:0]  m_write = '0;
  logic [65:0] m_addr = '0;
  logic [95:0] m_wdata = '0;
  logic [2:0]  m_ack;
  logic [2:0]  m_err;
  logic [31:0] m_rdata;
  logic [2:0]  grant;
  logic        xbus_req;
  logic        xbus_write;
  logic [21:0] xbus_addr;
  logic [31:0] xbus_wdata;
  logic [31:0] xbus_rdata = '0;
  logic        xbus_ack = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  xbus_arbiter #(.TIMEOUT(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .m_req      (m_req),
    .m_write    (m_write),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_ack      (m_ack),
    .m_err      (m_err),
    .m_rdata    (m_rdata),
    .grant      (grant),
    .xbus_req   (xbus_req),
    .xbus_write (xbus_write),
    .xbus_addr  (xbus_addr),
    .xbus_wdata (xbus_wdata),
    .xbus_rdata (xbus_rdata),
    .xbus_ack   (xbus_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (xbus_req !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'b0, xbus_req}, 32'd1);
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_grant"}, {29'b0, grant}, 32'd0);
    chk({tag, "_req"}, {31'b0, xbus_req}, 32'd0);
    chk({tag, "_ack"}, {29'b0, m_ack}, 32'd0);
    chk({tag, "_err"}, {29'b0, m_err}, 32'd0);
    chk({tag, "_rdata"}, m_rdata, 32'd0);
    chk({tag, "_addr"}, {10'b0, xbus_addr}, 32'd0);
    chk({tag, "_wr"}, {31'b0, xbus_write}, 32'd0);
  endtask

  initial begin
    // reset state
    #1;
    chk_idle_outs("rst");
    @(negedge clk);
    reset = 1'b1;

    // 1: master 0 read, slave acks in third req cycle
    m_req = 3'b001;
    m_write = 3'b000;
    m_addr[21:0] = 22'o17772037;
    wait_req("t1_req1");
    chk("t1_grant", {29'b0, grant}, 32'b001);
    chk("t1_addr", {10'b0, xbus_addr}, {10'b0, 22'o17772037});
    chk("t1_wr", {31'b0, xbus_write}, 32'd0);
    @(negedge clk);
    chk("t1_req2", {31'b0, xbus_req}, 32'd1);
    chk("t1_noack", {29'b0, m_ack}, 32'd0);
    @(negedge clk);
    chk("t1_req3", {31'b0, xbus_req}, 32'd1);
    xbus_ack = 1'b1;
    xbus_rdata = 32'h1234;
    @(negedge clk);
    chk("t1_ack", {29'b0, m_ack}, 32'b001);
    chk("t1_err", {29'b0, m_err}, 32'd0);
    chk("t1_rdata", m_rdata, 32'h1234);
    chk("t1_reqlo", {31'b0, xbus_req}, 32'd0);
    chk("t1_hold", {29'b0, grant}, 32'b001);
    m_req = 3'b000;
    xbus_ack = 1'b0;
    @(negedge clk);
    chk("t1_pulse", {29'b0, m_ack}, 32'd0);
    chk("t1_rel", {29'b0, grant}, 32'd0);

    // 2: all three request, round robin from reset
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      logic [2:0] eg;
      eg = (k == 1) ? 3'b010 : (k == 2) ? 3'b100 : 3'b001;
      wait_req($sformatf("t2_req%0d", k));
      chk($sformatf("t2_grant%0d", k), {29'b0, grant}, {29'b0, eg});
      xbus_ack = 1'b1;
      xbus_rdata = 32'hA0 + k;
      @(negedge clk);
      chk($sformatf("t2_ack%0d", k), {29'b0, m_ack}, {29'b0, eg});
      chk($sformatf("t2_rd%0d", k), m_rdata, 32'hA0 + k);
      xbus_ack = 1'b0;
      if (k == 3) m_req = 3'b000;
    end

    // 3: master 1 write, latched values stay put
    m_req = 3'b010;
    m_write = 3'b010;
    m_addr[43:22] = 22'o17772045;
    m_wdata[63:32] = 32'h0000000F;
    wait_req("t3_req");
    chk("t3_grant", {29'b0, grant}, 32'b010);
    chk("t3_wr", {31'b0, xbus_write}, 32'd1);
    chk("t3_addr", {10'b0, xbus_addr}, {10'b0, 22'o17772045});
    chk("t3_wdata", xbus_wdata, 32'h0000000F);
    m_addr[43:22] = 22'h3FFFFF;
    m_wdata[63:32] = 32'hDEADBEEF;
    m_write = 3'b000;
    @(negedge clk);
    chk("t3_addr2", {10'b0, xbus_addr}, {10'b0, 22'o17772045});
    xbus_ack = 1'b1;
    xbus_rdata = 32'h5A5A5A5A;
    @(negedge clk);
    chk("t3_ack", {29'b0, m_ack}, 32'b010);
    chk("t3_rdata", m_rdata, 32'hA3);
    chk("t3_addr3", {10'b0, xbus_addr}, {10'b0, 22'o17772045});
    chk("t3_wdata3", xbus_wdata, 32'h0000000F);
    chk("t3_wr3", {31'b0, xbus_write}, 32'd1);
    m_req = 3'b000;
    xbus_ack = 1'b0;

    // 4: silent slave, timeout of 8 cycles
    m_req = 3'b001;
    wait_req("t4_req");
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("t4_wait%0d", k), {29'b0, m_ack}, 32'd0);
    end
    @(negedge clk);
    chk("t4_ack", {29'b0, m_ack}, 32'b001);
    chk("t4_err", {29'b0, m_err}, 32'b001);
    chk("t4_rdata", m_rdata, 32'd0);
    chk("t4_reqlo", {31'b0, xbus_req}, 32'd0);
    m_req = 3'b000;
    @(negedge clk);
    chk("t4_errlo", {29'b0, m_err}, 32'd0);

    // 5: late ack drain with master 2 waiting
    m_req = 3'b001;
    wait_req("t5_req");
    xbus_ack = 1'b1;
    xbus_rdata = 32'h55;
    @(negedge clk);
    chk("t5_ack", {29'b0, m_ack}, 32'b001);
    chk("t5_rdata", m_rdata, 32'h55);
    m_req = 3'b100;
    @(negedge clk);
    chk("t5_hold1", {29'b0, grant}, 32'b001);
    chk("t5_reqlo1", {31'b0, xbus_req}, 32'd0);
    @(negedge clk);
    chk("t5_hold2", {29'b0, grant}, 32'b001);
    chk("t5_reqlo2", {31'b0, xbus_req}, 32'd0);
    xbus_ack = 1'b0;
    @(negedge clk);
    chk("t5_idle", {29'b0, grant}, 32'd0);
    chk("t5_reqlo3", {31'b0, xbus_req}, 32'd0);
    @(negedge clk);
    chk("t5_req2", {31'b0, xbus_req}, 32'd1);
    chk("t5_grant2", {29'b0, grant}, 32'b100);
    xbus_ack = 1'b1;
    xbus_rdata = 32'h66;
    @(negedge clk);
    chk("t5_ack2", {29'b0, m_ack}, 32'b100);
    chk("t5_rdata2", m_rdata, 32'h66);
    m_req = 3'b000;
    xbus_ack = 1'b0;

    // 6: async reset in S_REQ, then master 0 wins first
    m_req = 3'b001;
    wait_req("t6_req0");
    xbus_ack = 1'b1;
    @(negedge clk);
    chk("t6_ack0", {29'b0, m_ack}, 32'b001);
    m_req = 3'b000;
    xbus_ack = 1'b0;
    m_req = 3'b010;
    wait_req("t6_req1");
    chk("t6_grant1", {29'b0, grant}, 32'b010);
    #2;
    reset = 1'b0;
    #1;
    chk_idle_outs("t6_rst");
    @(negedge clk);
    chk("t6_rsthold", {29'b0, grant}, 32'd0);
    reset = 1'b1;
    m_req = 3'b011;
    wait_req("t6_req2");
    chk("t6_first", {29'b0, grant}, 32'b001);
    chk("t6_noack", {29'b0, m_ack}, 32'd0);
    xbus_ack = 1'b1;
    xbus_rdata = 32'h77;
    @(negedge clk);
    chk("t6_ack2", {29'b0, m_ack}, 32'b001);
    m_req = 3'b000;
    xbus_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
